// File: rtl/ss_desc_wbs.sv
// rtl/ss_desc_wbs.sv - Wishbone slave responder backing a 64-bit descriptor array
//
// Purpose: answers single and burst Wishbone cycles from the DMA descriptor port
// with ack, rty or err, and stores 2^AW descriptor entries of 64 bits each. A host
// port preloads and inspects entries. Beat and error counters give visibility.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i     Wishbone cycle, strobe, write enable
//   wbs_cab_i                burst hint (no effect on timing)
//   wbs_sel_i[3:0]           byte select, bit i enables byte i of both halves
//   wbs_adr_i[31:0]          byte address, entry index is [3+AW-1:3]
//   wbs_dat_i/dat64_i        write data low/high half
//   wbs_dat_o/dat64_o        read data low/high half
//   wbs_ack_o/rty_o/err_o    one-cycle response strobes
//   rty_inject, err_inject   force retry / error on the beat being decided
//   h_we, h_adr, h_dat       host write port (full 64-bit writes)
//   h_rdat                   host read data, registered
//   beat_cnt, err_cnt        acked beats (wraps), err responses (saturates)

module ss_desc_wbs #(
  parameter int          AW          = 6,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic          wbs_cab_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [31:0]   wbs_dat64_i,
  output logic [31:0]   wbs_dat_o,
  output logic [31:0]   wbs_dat64_o,
  output logic          wbs_ack_o,
  output logic          wbs_rty_o,
  output logic          wbs_err_o,
  input  logic          rty_inject,
  input  logic          err_inject,
  input  logic          h_we,
  input  logic [AW-1:0] h_adr,
  input  logic [63:0]   h_dat,
  output logic [63:0]   h_rdat,
  output logic [15:0]   beat_cnt,
  output logic [7:0]    err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nx;
  logic [3:0]    wait_cnt;
  logic [63:0]   mem [2**AW];

  logic          req;
  logic          in_win;
  logic [AW-1:0] idx;
  logic          decide;
  logic          dec_ack, dec_rty, dec_err;

  // Byte offset and burst hint are deliberately ignored.
  logic          unused_ok;
  assign unused_ok = ^{wbs_cab_i, wbs_adr_i[2:0]};

  assign req    = wbs_cyc_i & wbs_stb_i;
  assign in_win = (wbs_adr_i[31:3+AW] == BASE[31:3+AW]);
  assign idx    = wbs_adr_i[3+AW-1:3];

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; S_RESP never looks at the request so the master can
  // update address/data after the response before the next request edge.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req) state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!req)                 state_nx = S_IDLE;
        else if (wait_cnt == 4'd1) state_nx = S_RESP;
      end
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Decision logic: err beats rty beats ack.
  always_comb begin
    decide = 1'b0;
    case (state)
      S_IDLE:  decide = req && (WAIT_CYCLES == 0);
      S_WAIT:  decide = req && (wait_cnt == 4'd1);
      default: decide = 1'b0;
    endcase
    dec_err = decide & (~in_win | err_inject);
    dec_rty = decide & ~dec_err & rty_inject;
    dec_ack = decide & ~dec_err & ~rty_inject;
  end

  // Registered responses, read data, counters and host read port.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wait_cnt    <= 4'd0;
      wbs_ack_o   <= 1'b0;
      wbs_rty_o   <= 1'b0;
      wbs_err_o   <= 1'b0;
      wbs_dat_o   <= 32'd0;
      wbs_dat64_o <= 32'd0;
      h_rdat      <= 64'd0;
      beat_cnt    <= 16'd0;
      err_cnt     <= 8'd0;
    end else begin
      if (state == S_IDLE && req) wait_cnt <= 4'(WAIT_CYCLES);
      else if (state == S_WAIT)   wait_cnt <= wait_cnt - 4'd1;

      wbs_ack_o <= dec_ack;
      wbs_rty_o <= dec_rty;
      wbs_err_o <= dec_err;

      if (dec_ack && !wbs_we_i) {wbs_dat64_o, wbs_dat_o} <= mem[idx];

      if (wbs_ack_o)                      beat_cnt <= beat_cnt + 16'd1;
      if (wbs_err_o && err_cnt != 8'hFF)  err_cnt  <= err_cnt + 8'd1;

      h_rdat <= mem[h_adr];
    end
  end

  // Array: host write first, so a bus write to the same entry overrides it.
  // Writes are suppressed while reset is held so an abandoned beat leaves no trace.
  always_ff @(posedge wb_clk_i) begin
    if (h_we) mem[h_adr] <= h_dat;
    if (dec_ack && wbs_we_i && !wb_rst_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wbs_sel_i[i]) begin
          mem[idx][8*i +: 8]      <= wbs_dat_i[8*i +: 8];
          mem[idx][32+8*i +: 8]   <= wbs_dat64_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ss_desc_wbs.sv
// tb/tb_ss_desc_wbs.sv - randomized self-checking bench for ss_desc_wbs

module tb_ss_desc_wbs;
  localparam int          AW   = 6;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          NENT = 2**AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cyc [2];
  logic          stb [2];
  logic          we, cab;
  logic [3:0]    sel;
  logic [31:0]   adr, dat_i, dat64_i;
  logic          rinj, einj;
  logic          h_we;
  logic [AW-1:0] h_adr;
  logic [63:0]   h_dat;

  logic [31:0]   dat_o [2];
  logic [31:0]   dat64_o [2];
  logic          ack [2];
  logic          rty [2];
  logic          err [2];
  logic [63:0]   h_rdat [2];
  logic [15:0]   beat_cnt [2];
  logic [7:0]    err_cnt [2];

  // Instance 0: no wait states; instance 1: three wait states.
  ss_desc_wbs #(.AW(AW), .BASE(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we), .wbs_cab_i(cab),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat64_i(dat64_i),
    .wbs_dat_o(dat_o[0]), .wbs_dat64_o(dat64_o[0]),
    .wbs_ack_o(ack[0]), .wbs_rty_o(rty[0]), .wbs_err_o(err[0]),
    .rty_inject(rinj), .err_inject(einj),
    .h_we(h_we), .h_adr(h_adr), .h_dat(h_dat), .h_rdat(h_rdat[0]),
    .beat_cnt(beat_cnt[0]), .err_cnt(err_cnt[0]));

  ss_desc_wbs #(.AW(AW), .BASE(BASE), .WAIT_CYCLES(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we), .wbs_cab_i(cab),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat64_i(dat64_i),
    .wbs_dat_o(dat_o[1]), .wbs_dat64_o(dat64_o[1]),
    .wbs_ack_o(ack[1]), .wbs_rty_o(rty[1]), .wbs_err_o(err[1]),
    .rty_inject(rinj), .err_inject(einj),
    .h_we(h_we), .h_adr(h_adr), .h_dat(h_dat), .h_rdat(h_rdat[1]),
    .beat_cnt(beat_cnt[1]), .err_cnt(err_cnt[1]));

  // Reference model
  logic [63:0] m_mem [2][NENT];
  logic [63:0] m_rd [2];
  int          m_beats [2];
  int          m_errs [2];
  int          waits [2] = '{0, 3};

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  always @(posedge clk) cyc_n++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic host_write(input int a, input logic [63:0] v);
    @(negedge clk);
    h_we = 1'b1; h_adr = AW'(a); h_dat = v;
    @(negedge clk);
    h_we = 1'b0;
    m_mem[0][a] = v;
    m_mem[1][a] = v;
  endtask

  task automatic host_check(input int d, input int a, input string tag);
    @(negedge clk);
    h_adr = AW'(a);
    @(negedge clk);
    check(tag, h_rdat[d], m_mem[d][a]);
  endtask

  // One beat, started at a falling edge. Checks latency, response kind, read data
  // and counters, and that the strobe lasts a single cycle.
  task automatic beat(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [63:0] wd, input bit ri, input bit ei, input bit last,
                      input string tag);
    int   lat;
    bit   got;
    bit   inwin;
    int   ix;
    logic [2:0] expv;
    cyc[d] = 1'b1; stb[d] = 1'b1; we = w; adr = a; sel = s;
    {dat64_i, dat_i} = wd; rinj = ri; einj = ei;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      h_we = 1'b0;
      lat++;
      got = ack[d] | rty[d] | err[d];
    end
    check({tag, " latency"}, 64'(lat), 64'(1 + waits[d]));
    inwin = (a[31:3+AW] == BASE[31:3+AW]);
    ix    = int'(a[3+AW-1:3]);
    expv  = (ei || !inwin) ? 3'b100 : (ri ? 3'b010 : 3'b001);
    check({tag, " resp"}, 64'({err[d], rty[d], ack[d]}), 64'(expv));
    if (expv == 3'b001) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) begin
            m_mem[d][ix][8*i +: 8]    = wd[8*i +: 8];
            m_mem[d][ix][32+8*i +: 8] = wd[32+8*i +: 8];
          end
      end else begin
        m_rd[d] = m_mem[d][ix];
      end
      m_beats[d]++;
    end else if (expv == 3'b100 && m_errs[d] < 255) begin
      m_errs[d]++;
    end
    check({tag, " rdata"}, {dat64_o[d], dat_o[d]}, m_rd[d]);
    if (last) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; rinj = 1'b0; einj = 1'b0;
    end
    @(negedge clk);
    check({tag, " one-cycle"}, 64'({err[d], rty[d], ack[d]}), 64'd0);
    check({tag, " beat_cnt"}, 64'(beat_cnt[d]), 64'(m_beats[d][15:0]));
    check({tag, " err_cnt"}, 64'(err_cnt[d]), 64'(m_errs[d]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int nstb;
    rst = 1'b1;
    cyc[0] = 0; cyc[1] = 0; stb[0] = 0; stb[1] = 0;
    we = 0; cab = 0; sel = 0; adr = 0; dat_i = 0; dat64_i = 0;
    rinj = 0; einj = 0; h_we = 0; h_adr = 0; h_dat = 0;
    for (int d = 0; d < 2; d++) begin
      m_rd[d] = 64'd0; m_beats[d] = 0; m_errs[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset strobes", 64'({ack[d], rty[d], err[d]}), 64'd0);
      check("reset rdata", {dat64_o[d], dat_o[d]}, 64'd0);
      check("reset h_rdat", h_rdat[d], 64'd0);
      check("reset counters", 64'({beat_cnt[d], err_cnt[d]}), 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < NENT; i++) host_write(i, {$urandom(), $urandom()});
    host_write(2, 64'h1111_2222_3333_4444);
    host_write(7, 64'hFFFF_FFFF_FFFF_FFFF);

    // 4-beat burst read of entries 2..5 with no wait states
    @(negedge clk);
    cab = 1'b1;
    t0 = cyc_n;
    beat(0, 0, BASE + 32'h10, 4'hF, 64'd0, 0, 0, 0, "burst0");
    check("burst first beat", {dat64_o[0], dat_o[0]}, 64'h1111_2222_3333_4444);
    beat(0, 0, BASE + 32'h18, 4'hF, 64'd0, 0, 0, 0, "burst1");
    beat(0, 0, BASE + 32'h20, 4'hF, 64'd0, 0, 0, 0, "burst2");
    beat(0, 0, BASE + 32'h28, 4'hF, 64'd0, 0, 0, 1, "burst3");
    check("burst cycles", 64'(cyc_n - t0), 64'd8);
    check("burst beat_cnt", 64'(beat_cnt[0]), 64'd4);
    cab = 1'b0;

    // Masked write
    beat(0, 1, BASE + 32'h38, 4'b0011, 64'hAAAA_AAAA_BBBB_BBBB, 0, 0, 1, "mwrite");
    host_check(0, 7, "mwrite entry");
    check("mwrite value", h_rdat[0], 64'hFFFF_AAAA_FFFF_BBBB);

    // Wait states
    @(negedge clk);
    beat(1, 0, BASE + 32'h18, 4'hF, 64'd0, 0, 0, 1, "wait read");
    beat(1, 1, BASE + 32'h18, 4'hF, 64'h0123_4567_89AB_CDEF, 0, 0, 1, "wait write");
    host_check(1, 3, "wait write entry");

    // Abort in the second wait cycle: no strobe, no write
    @(negedge clk);
    cyc[1] = 1; stb[1] = 1; we = 1; adr = BASE + 32'h20; sel = 4'hF;
    {dat64_i, dat_i} = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    cyc[1] = 0; stb[1] = 0;
    nstb = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1] | rty[1] | err[1]) nstb++;
    end
    check("abort strobes", 64'(nstb), 64'd0);
    host_check(1, 4, "abort entry");

    // Error and retry
    @(negedge clk);
    beat(0, 0, BASE + 32'(NENT * 8), 4'hF, 64'd0, 0, 0, 1, "oow read");
    check("oow err_cnt", 64'(err_cnt[0]), 64'd1);
    beat(0, 1, BASE + 32'h48, 4'hF, 64'h5555_5555_5555_5555, 0, 1, 1, "err inj write");
    host_check(0, 9, "err inj entry");
    beat(0, 1, BASE + 32'h50, 4'hF, 64'h6666_6666_6666_6666, 1, 0, 1, "rty write");
    host_check(0, 10, "rty entry");
    @(negedge clk);
    beat(0, 0, BASE + 32'h50, 4'hF, 64'd0, 1, 1, 1, "err+rty");

    // Address wrap: last entry then +8 leaves the window
    beat(0, 0, BASE + 32'(NENT * 8 - 8), 4'hF, 64'd0, 0, 0, 0, "wrap last");
    beat(0, 0, BASE + 32'(NENT * 8), 4'hF, 64'd0, 0, 0, 1, "wrap next");

    // Host/bus collision on entry 0: bus wins
    @(negedge clk);
    h_we = 1'b1; h_adr = '0; h_dat = 64'h1;
    m_mem[0][0] = 64'h1;
    m_mem[1][0] = 64'h1;
    beat(0, 1, BASE, 4'hF, 64'h2, 0, 0, 1, "collide");
    host_check(0, 0, "collide entry");
    check("collide value", h_rdat[0], 64'h2);
    host_check(1, 0, "collide other");

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      a = {23'd0, 6'($urandom_range(0, NENT - 1)), 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h0000_0200;
      cab = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0)
        host_write(int'($urandom_range(0, NENT - 1)), {$urandom(), $urandom()});
      @(negedge clk);
      beat(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
           {$urandom(), $urandom()}, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, 1, "rand");
      if ($urandom_range(0, 3) == 0)
        host_check(d, int'($urandom_range(0, NENT - 1)), "rand host");
    end

    // Reset during the response cycle
    @(negedge clk);
    cyc[0] = 1; stb[0] = 1; we = 0; adr = BASE + 32'h20; sel = 4'hF;
    @(posedge clk);
    #1;
    check("pre-reset ack", 64'(ack[0]), 64'd1);
    rst = 1'b1;
    #1;
    check("reset ack", 64'(ack[0]), 64'd0);
    check("reset beat_cnt", 64'(beat_cnt[0]), 64'd0);
    check("reset err_cnt", 64'(err_cnt[0]), 64'd0);
    check("reset dat", {dat64_o[0], dat_o[0]}, 64'd0);
    @(negedge clk);
    cyc[0] = 0; stb[0] = 0;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_rd[d] = 64'd0; m_beats[d] = 0; m_errs[d] = 0;
    end
    @(negedge clk);
    check("post-reset strobes", 64'({ack[0], rty[0], err[0]}), 64'd0);
    beat(0, 0, BASE + 32'h38, 4'hF, 64'd0, 0, 0, 1, "post-reset read");
    host_check(0, 7, "post-reset entry");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
